// File: rtl/mux4_arbiter.sv
// mux4_arbiter
//   Round-robin arbiter that shares one 4:1 mux datapath between four
//   requesters. Exactly one requester holds the grant at a time; the owner
//   keeps it until it drops its request, and ownership passes to the next
//   requester with no idle cycle in between.
//
//   Optional build macro ARB_TIMEOUT_EN: adds a hold counter that forces
//   rotation after MAX_HOLD consecutive grant cycles, but only when another
//   requester is waiting. Without the macro, preempt is tied low and an owner
//   may hold the grant indefinitely.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles before forced rotation (2..255),
//             only meaningful with ARB_TIMEOUT_EN
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   req      request per requester, bit i = requester i
//   gnt      registered one-hot grant, all-zero when idle
//   sel      registered index of the granted requester (mux select);
//            holds its last value while idle
//   busy     registered, 1 while any grant is active
//   preempt  one-cycle pulse, aligned with the new gnt, when a grant is
//            revoked by timeout

module mux4_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       preempt
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
        $error("mux4_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [3:0] gnt_n;
    logic [1:0] sel_n;
    logic       busy_n;
    logic [1:0] last, last_n;

    // Winner of the current cycle's arbitration: {found, index}.
    logic [2:0] pick;
    logic       do_grant;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt, hold_cnt_n;
    logic       preempt_n;
    logic [3:0] others;
`endif

    // Search order starts just past ptr and wraps, ending on ptr itself,
    // so the most recent owner has the lowest priority.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                           input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!res[2] && cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        sel_n    = sel;
        busy_n   = busy;
        last_n   = last;
        pick     = '0;
        do_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_n = hold_cnt;
        preempt_n  = 1'b0;
        others     = req & ~(4'b0001 << sel);
`endif

        case (state)
            IDLE: begin
                if (|req) begin
                    pick     = rr_pick(req, last);
                    do_grant = 1'b1;
                end
            end

            GRANT: begin
                // While granted, sel is the owner index.
                if (!req[sel]) begin
                    last_n = sel;
                    pick   = rr_pick(req, sel);
                    if (pick[2]) begin
                        do_grant = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        busy_n  = 1'b0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (hold_cnt == HOLD_LIMIT && |others) begin
                        // Owner is masked out so the rotation cannot land
                        // back on it.
                        last_n    = sel;
                        pick      = rr_pick(others, sel);
                        do_grant  = 1'b1;
                        preempt_n = 1'b1;
                    end else if (hold_cnt != HOLD_LIMIT) begin
                        hold_cnt_n = hold_cnt + 8'd1;
                    end
`endif
                end
            end

            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_n = GRANT;
            gnt_n   = 4'b0001 << pick[1:0];
            sel_n   = pick[1:0];
            busy_n  = 1'b1;
            last_n  = pick[1:0];
`ifdef ARB_TIMEOUT_EN
            hold_cnt_n = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            last  <= 2'd3;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            busy  <= busy_n;
            last  <= last_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_n;
            preempt  <= preempt_n;
        end
    end
`else
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_arbiter.sv
// Testbench for mux4_arbiter: fixed vector table for the directed scenarios,
// hand-written timeout sequences, and randomized traffic against a
// behavioural reference model. Build with ARB_TIMEOUT_EN defined to cover
// the timeout feature.

module tb_mux4_arbiter;

    localparam int HOLD = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    mux4_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: owner index (-1 = idle), last owner, held select,
    // consecutive cycles of the current grant, timeout pulse.
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_hold  = 0;
    bit m_pre   = 1'b0;

    function automatic int rr(input logic [3:0] c, input int from);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (from + k) % 4;
            if (c[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_owner = w;
        m_sel   = w;
        m_last  = w;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic r, input logic [3:0] q);
        int w;
        m_pre = 1'b0;
        if (r) begin
            m_owner = -1;
            m_last  = 3;
            m_sel   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            w = rr(q, m_last);
            if (w >= 0) take(w);
        end else if (!q[m_owner]) begin
            m_last = m_owner;
            w = rr(q, m_last);
            if (w >= 0) take(w);
            else m_owner = -1;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (m_hold == HOLD - 1 && (q & ~(4'b0001 << m_owner)) != 4'b0000) begin
                m_last = m_owner;
                take(rr(q & ~(4'b0001 << m_owner), m_owner));
                m_pre = 1'b1;
            end else if (m_hold < HOLD - 1) begin
                m_hold++;
            end
`endif
        end
    endtask

    task automatic check(input string name, input logic [3:0] eg,
                         input logic [1:0] es, input logic eb, input logic ep);
        n_vec++;
        if ({gnt, sel, busy, preempt} !== {eg, es, eb, ep}) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b preempt=%b, want gnt=%b sel=%0d busy=%b preempt=%b",
                     name, gnt, sel, busy, preempt, eg, es, eb, ep);
        end
    endtask

    task automatic check_invariant();
        n_vec++;
        if ($countones(gnt) > 1 || (gnt != 4'b0000 && gnt != (4'b0001 << sel))) begin
            n_bad++;
            $display("FAIL invariant: got gnt=%b sel=%0d, want one-hot-or-zero gnt matching sel",
                     gnt, sel);
        end
    endtask

    // Drive inputs, take one clock edge, advance the model, sample #1 later.
    task automatic step(input logic r, input logic [3:0] q);
        reset = r;
        req   = q;
        @(posedge clk);
        model_step(r, q);
        #1;
        check_invariant();
    endtask

    task automatic check_model(input string name);
        check(name, (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner), 2'(m_sel),
              m_owner >= 0, m_pre);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       pre;
    } vec_t;

    vec_t tbl [25];

    initial begin
        logic [3:0] q;
        logic [3:0] flip;
        logic       r;

        // reset with all requesting, then first grant to requester 0
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        // single requester 2, then release: sel stays 2 while idle
        tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
        // full rotation 0,1,2,3,0 with zero-bubble handoffs
        tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0};
        // owner 1 releases with 1001 pending: 3 wins before 0
        tbl[17] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        // reset while requester 2 owns the grant
        tbl[20] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[22] = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].rst, tbl[i].req);
            check($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].sel,
                  tbl[i].busy, tbl[i].pre);
        end

`ifdef ARB_TIMEOUT_EN
        step(1'b1, 4'b0000);
        check("timeout_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < HOLD; i++) begin
            step(1'b0, 4'b0011);
            check($sformatf("timeout_hold[%0d]", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0011);
        check("timeout_preempt", 4'b0010, 2'd1, 1'b1, 1'b1);
        step(1'b0, 4'b0011);
        check("timeout_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(1'b0, 4'b0001);
        check("timeout_rejoin", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 2 * HOLD; i++) begin
            step(1'b0, 4'b0001);
            check($sformatf("solo_hold[%0d]", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`else
        step(1'b1, 4'b0000);
        check("hold_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0011);
            check($sformatf("hold_forever[%0d]", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif

        // randomized traffic: requests are sticky with random flips
        step(1'b1, 4'b0000);
        check_model("random_reset");
        q = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            flip = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) flip[b] = 1'b1;
            end
            q = q ^ flip;
            r = ($urandom_range(0, 49) == 0);
            step(r, q);
            check_model($sformatf("random[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux4_arbiter.md
Name: mux4_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 mux datapath between four requesters.
- Grants exactly one requester at a time and drives the matching 2-bit mux select (sel[1:0] = index of granted input).
- Owner keeps the grant until it drops its request. Handoff to the next requester happens with no idle cycle.
- Sits between requesting units and the shared 4:1 mux in the CPU datapath.

Parameters:
- MAX_HOLD, 16, max consecutive grant cycles before forced rotation (used only with ARB_TIMEOUT_EN); legal 2..255.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- sel  output  2  registered binary index of granted requester; drives the mux sel.
- busy  output  1  registered; 1 while any grant is active.
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout (0 when feature absent).

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset is sampled synchronously and overrides everything.
  - Reset values: gnt=0000, sel=00, busy=0, preempt=0, last-owner pointer=3, hold counter=0, state=IDLE.
  - With last-owner=3 after reset, requester 0 has highest priority first.
- States: IDLE, GRANT.
- Round-robin pick over a candidate vector C:
  - Search indices last+1, last+2, last+3, last (mod 4).
  - The first set bit wins.
- IDLE:
  - req==0000: stay IDLE.
  - Otherwise: pick over C=req, go to GRANT, set gnt/sel to the winner, busy=1.
  - Latency from req to gnt is 1 cycle.
- GRANT (owner o):
  - req[o]==1 and no preemption: hold gnt/sel unchanged.
  - req[o]==0: set last=o.
    - Pick over C=req. If nonzero, grant the winner next cycle (zero-bubble handoff).
    - Otherwise go to IDLE with gnt=0000, sel unchanged, busy=0.
- last is also updated to the winner on every new grant.
  - Fairness: a continuously requesting input waits at most 3 full ownerships.
- sel holds its last value when idle, so the mux output is stable. Consumers qualify the output with busy/gnt.
- gnt is never multi-hot. gnt[i]=1 implies sel==i.
- Requests that rise and fall while another requester owns the grant are not latched (level-sensitive).
- Reset mid-grant: the next cycle shows the reset values. Arbitration restarts from requester 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 while req[o]==1 and some other req bit is set, the owner is preempted.
    - Set last=o, pick over C=req with bit o masked, and grant that winner next cycle.
    - preempt pulses 1 for that one cycle, aligned with the new gnt.
  - If no other request is pending, the owner keeps the grant and the counter saturates at MAX_HOLD-1.
  - The preempted requester rejoins arbitration normally if it keeps requesting.
- Not defined:
  - No counter logic.
  - preempt is tied to 0.
  - The owner holds indefinitely.

Test Plan:
- Reset with req=1111 asserted: gnt=0000, sel=00, busy=0 during reset. First cycle after reset release → gnt=0001, sel=00.
- Single requester: req=0100 at cycle n → gnt=0100, sel=10, busy=1 at n+1. Drop req at m → gnt=0000, busy=0, sel=10 at m+1.
- All four requesting, each owner drops its req after 2 cycles then reraises: grant order 0,1,2,3,0, no idle cycle between owners.
- Handoff skip: owner 1 releases while req=1001 → next gnt=1000 (index 3 before 0). Next release → gnt=0001.
- Reset asserted mid-grant (owner 2): gnt=0000, sel=00 the next cycle. With req=0110 after release → gnt=0010.
- With ARB_TIMEOUT_EN, MAX_HOLD=4:
  - Owner 0 holds, req=0011 throughout → gnt moves to 0010 after 4 grant cycles, preempt=1 for exactly one cycle.
  - With req=0001 only, the grant is held past 4 cycles and preempt stays 0.
